// File: rtl/firewall_dispatch_if.sv
// firewall_dispatch_if: record stream, engine request/response and result
// stream bundle; the dispatcher sits on the slave side.
interface firewall_dispatch_if #(
    parameter int HDR_W   = 104,
    parameter int KEY_W   = 72,
    parameter int SLOT_W  = 8,
    parameter int NUM_ENG = 2,
    parameter int CNT_W   = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic [SLOT_W-1:0]        in_slot;
    logic [HDR_W-1:0]         in_header;
    logic [NUM_ENG-1:0]       eng_req_valid;
    logic [NUM_ENG-1:0]       eng_req_ready;
    logic [NUM_ENG*KEY_W-1:0] eng_key;
    logic [NUM_ENG-1:0]       eng_res_valid;
    logic [NUM_ENG-1:0]       eng_res;
    logic                     out_valid;
    logic                     out_ready;
    logic [SLOT_W-1:0]        out_slot;
    logic                     out_res;
    logic                     out_timeout;
    logic [CNT_W-1:0]         cnt_pass;
    logic [CNT_W-1:0]         cnt_drop;
    logic [CNT_W-1:0]         cnt_timeout;

    modport master (
        output in_valid, in_slot, in_header,
        output eng_req_ready, eng_res_valid, eng_res,
        output out_ready,
        input  in_ready, eng_req_valid, eng_key,
        input  out_valid, out_slot, out_res, out_timeout,
        input  cnt_pass, cnt_drop, cnt_timeout
    );

    modport slave (
        input  in_valid, in_slot, in_header,
        input  eng_req_ready, eng_res_valid, eng_res,
        input  out_ready,
        output in_ready, eng_req_valid, eng_key,
        output out_valid, out_slot, out_res, out_timeout,
        output cnt_pass, cnt_drop, cnt_timeout
    );
endinterface

// File: rtl/firewall_dispatch.sv
// firewall_dispatch: round-robin dispatch of header lookups to bloom engines,
// in-order result return, per-engine timeout and saturating statistics.
module firewall_dispatch #(
    parameter int HDR_W   = 104,
    parameter int KEY_W   = 72,
    parameter int SLOT_W  = 8,
    parameter int NUM_ENG = 2,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input logic                clk,
    input logic                reset,
    firewall_dispatch_if.slave bus
);
    localparam int EW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam int QW = $clog2(NUM_ENG + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } eng_state_t;

    eng_state_t        state_q [NUM_ENG];
    eng_state_t        state_d [NUM_ENG];
    logic [TW-1:0]     timer_q [NUM_ENG];
    logic [TW-1:0]     timer_d [NUM_ENG];
    logic [KEY_W-1:0]  key_q   [NUM_ENG];
    logic [SLOT_W-1:0] slot_q  [NUM_ENG];
    logic              res_q   [NUM_ENG];
    logic              tmo_q   [NUM_ENG];
    logic              hit     [NUM_ENG];
    logic              expire  [NUM_ENG];

    logic [EW-1:0]     ord_q   [NUM_ENG];
    logic [EW-1:0]     head_q;
    logic [EW-1:0]     tail_q;
    logic [EW-1:0]     rr_q;
    logic [EW-1:0]     sel;
    logic [EW-1:0]     head_eng;
    logic [QW-1:0]     cnt_q;
    logic              any_idle;
    logic              accept;
    logic              out_valid;
    logic              pop;

    logic [CNT_W-1:0]  pass_q;
    logic [CNT_W-1:0]  drop_q;
    logic [CNT_W-1:0]  tmo_cnt_q;

    logic              unused_hdr;

    function automatic logic [EW-1:0] wrap_inc(input logic [EW-1:0] p);
        return (int'(p) == NUM_ENG - 1) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [EW-1:0] rot(input logic [EW-1:0] base,
                                          input int k);
        return EW'((int'(base) + k) % NUM_ENG);
    endfunction

    // pick the first idle engine at or after the round-robin pointer
    always_comb begin
        any_idle = 1'b0;
        sel      = rr_q;
        for (int k = NUM_ENG - 1; k >= 0; k--) begin
            if (state_q[rot(rr_q, k)] == S_IDLE) begin
                any_idle = 1'b1;
                sel      = rot(rr_q, k);
            end
        end
    end

    assign bus.in_ready = !reset && any_idle;
    assign accept       = bus.in_valid && bus.in_ready;
    assign head_eng     = ord_q[head_q];
    assign out_valid    = (cnt_q != '0) && (state_q[head_eng] == S_DONE);
    assign pop          = out_valid && bus.out_ready;
    assign unused_hdr   = ^bus.in_header;

    // per-engine next state: issue, wait with timeout, hold until popped
    always_comb begin
        for (int i = 0; i < NUM_ENG; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            hit[i]     = 1'b0;
            expire[i]  = 1'b0;
            unique case (state_q[i])
                S_IDLE: begin
                    if (accept && sel == EW'(i))
                        state_d[i] = S_ISSUE;
                end
                S_ISSUE: begin
                    if (bus.eng_req_ready[i]) begin
                        state_d[i] = S_WAIT;
                        timer_d[i] = '0;
                    end
                end
                S_WAIT: begin
                    if (bus.eng_res_valid[i]) begin
                        hit[i]     = 1'b1;
                        state_d[i] = S_DONE;
                    end else if (timer_q[i] == TW'(TIMEOUT - 1)) begin
                        expire[i]  = 1'b1;
                        state_d[i] = S_DONE;
                    end else begin
                        timer_d[i] = timer_q[i] + 1'b1;
                    end
                end
                S_DONE: begin
                    if (pop && head_eng == EW'(i))
                        state_d[i] = S_IDLE;
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    // engine state register plus the record and result it carries
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENG; i++) begin
                state_q[i] <= S_IDLE;
                timer_q[i] <= '0;
                key_q[i]   <= '0;
                slot_q[i]  <= '0;
                res_q[i]   <= 1'b0;
                tmo_q[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_ENG; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
                if (accept && sel == EW'(i)) begin
                    key_q[i]  <= bus.in_header[HDR_W-1 -: KEY_W];
                    slot_q[i] <= bus.in_slot;
                end
                if (hit[i]) begin
                    res_q[i] <= bus.eng_res[i];
                    tmo_q[i] <= 1'b0;
                end else if (expire[i]) begin
                    res_q[i] <= 1'b0;
                    tmo_q[i] <= 1'b1;
                end
            end
        end
    end

    // arrival-order queue of engine indices and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            rr_q   <= '0;
            for (int i = 0; i < NUM_ENG; i++)
                ord_q[i] <= '0;
        end else begin
            if (accept) begin
                ord_q[tail_q] <= sel;
                tail_q        <= wrap_inc(tail_q);
                rr_q          <= wrap_inc(sel);
            end
            if (pop)
                head_q <= wrap_inc(head_q);
            if (accept && !pop)
                cnt_q <= cnt_q + 1'b1;
            else if (pop && !accept)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    // saturating pass/drop/timeout statistics, updated on each pop
    always_ff @(posedge clk) begin
        if (reset) begin
            pass_q    <= '0;
            drop_q    <= '0;
            tmo_cnt_q <= '0;
        end else if (pop) begin
            if (res_q[head_eng]) begin
                if (pass_q != '1)
                    pass_q <= pass_q + 1'b1;
            end else begin
                if (drop_q != '1)
                    drop_q <= drop_q + 1'b1;
            end
            if (tmo_q[head_eng] && tmo_cnt_q != '1)
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // engine request side driven straight from the engine registers
    always_comb begin
        bus.eng_req_valid = '0;
        bus.eng_key       = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            bus.eng_req_valid[i]           = (state_q[i] == S_ISSUE);
            bus.eng_key[i*KEY_W +: KEY_W]  = key_q[i];
        end
    end

    assign bus.out_valid   = out_valid;
    assign bus.out_slot    = out_valid ? slot_q[head_eng] : '0;
    assign bus.out_res     = out_valid && res_q[head_eng];
    assign bus.out_timeout = out_valid && tmo_q[head_eng];
    assign bus.cnt_pass    = pass_q;
    assign bus.cnt_drop    = drop_q;
    assign bus.cnt_timeout = tmo_cnt_q;
endmodule

// File: tb/tb_firewall_dispatch.sv
// tb_firewall_dispatch: directed scenarios then random traffic, checked
// against a cycle-count reference model of dispatch, ordering and stats.
module tb_firewall_dispatch;
    localparam int HDR_W  = 104;
    localparam int KEY_W  = 72;
    localparam int SLOT_W = 8;
    localparam int NE     = 2;
    localparam int TMO    = 4;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    firewall_dispatch_if #(
        .HDR_W(HDR_W), .KEY_W(KEY_W), .SLOT_W(SLOT_W),
        .NUM_ENG(NE), .CNT_W(CNT_W)
    ) bus ();

    firewall_dispatch #(
        .HDR_W(HDR_W), .KEY_W(KEY_W), .SLOT_W(SLOT_W),
        .NUM_ENG(NE), .TIMEOUT(TMO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    bit             busy    [NE];
    bit             iss     [NE];
    int             e_slot  [NE];
    logic [KEY_W-1:0] e_key [NE];
    bit             e_res   [NE];
    bit             e_tmo   [NE];
    int             fire_at [NE];
    bit             f_res   [NE];
    int             done_at [NE];
    int             plan_d  [NE];
    bit             plan_r  [NE];
    int             ord [$];
    int             rr;
    int             m_pass, m_drop, m_tmo;
    bit             rnd;
    bit             last_acc;
    int             slot_ctr;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic bit m_done(input int e);
        return busy[e] && !iss[e] && cyc >= done_at[e];
    endfunction

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic m_reset();
        for (int e = 0; e < NE; e++) begin
            busy[e] = 1'b0;
            iss[e]  = 1'b0;
        end
        ord.delete();
        rr     = 0;
        m_pass = 0;
        m_drop = 0;
        m_tmo  = 0;
    endtask

    // one clock: drive, check at the falling edge, then advance the model
    task automatic tick();
        bit acc, pop, free, exp_ov;
        bit hs [NE];
        int sel, h;
        int slot_in;
        logic [KEY_W-1:0] key_in;
        if (rnd) begin
            reset         = ($urandom_range(0, 299) == 0);
            bus.in_valid  = $urandom_range(0, 1);
            bus.in_slot   = SLOT_W'(slot_ctr);
            bus.in_header = HDR_W'({$urandom(), $urandom(),
                                    $urandom(), $urandom()});
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int e = 0; e < NE; e++) begin
                bus.eng_req_ready[e] = ($urandom_range(0, 2) != 0);
                plan_d[e] = $urandom_range(0, TMO + 2);
                plan_r[e] = $urandom_range(0, 1);
            end
        end
        for (int e = 0; e < NE; e++) begin
            bus.eng_res_valid[e] = (fire_at[e] == cyc + 1);
            bus.eng_res[e]       = f_res[e];
        end
        #4;
        free = 1'b0;
        sel  = 0;
        for (int k = NE - 1; k >= 0; k--) begin
            if (!busy[(rr + k) % NE]) begin
                free = 1'b1;
                sel  = (rr + k) % NE;
            end
        end
        exp_ov = (ord.size() > 0) && m_done(ord[0]);
        chk("in_ready", bus.in_ready, !reset && free);
        chk("out_valid", bus.out_valid, exp_ov);
        if (exp_ov) begin
            h = ord[0];
            chk("out_slot", bus.out_slot, e_slot[h]);
            chk("out_res", bus.out_res, e_res[h]);
            chk("out_timeout", bus.out_timeout, e_tmo[h]);
        end
        for (int e = 0; e < NE; e++) begin
            chk("eng_req_valid", bus.eng_req_valid[e], iss[e]);
            if (iss[e])
                chk("eng_key", bus.eng_key[e*KEY_W +: KEY_W], e_key[e]);
        end
        chk("cnt_pass", bus.cnt_pass, m_pass);
        chk("cnt_drop", bus.cnt_drop, m_drop);
        chk("cnt_timeout", bus.cnt_timeout, m_tmo);
        acc     = bus.in_valid && !reset && free;
        pop     = exp_ov && bus.out_ready;
        slot_in = int'(bus.in_slot);
        key_in  = bus.in_header[HDR_W-1 -: KEY_W];
        for (int e = 0; e < NE; e++)
            hs[e] = iss[e] && bus.eng_req_ready[e];
        @(posedge clk);
        #1;
        cyc++;
        last_acc = acc;
        if (reset) begin
            m_reset();
        end else begin
            if (acc) begin
                busy[sel]   = 1'b1;
                iss[sel]    = 1'b1;
                e_slot[sel] = slot_in;
                e_key[sel]  = key_in;
                ord.push_back(sel);
                rr = (sel + 1) % NE;
                slot_ctr++;
            end
            if (pop) begin
                h = ord.pop_front();
                busy[h] = 1'b0;
                if (e_res[h]) m_pass = sat(m_pass);
                else          m_drop = sat(m_drop);
                if (e_tmo[h]) m_tmo = sat(m_tmo);
            end
            for (int e = 0; e < NE; e++) begin
                if (hs[e]) begin
                    iss[e]     = 1'b0;
                    e_tmo[e]   = (plan_d[e] >= TMO);
                    e_res[e]   = plan_r[e] && (plan_d[e] < TMO);
                    fire_at[e] = cyc + 1 + plan_d[e];
                    f_res[e]   = plan_r[e];
                    done_at[e] = (plan_d[e] < TMO) ? cyc + 1 + plan_d[e]
                                                   : cyc + TMO;
                end
            end
        end
    endtask

    task automatic send(input int slot);
        bus.in_valid  = 1'b1;
        bus.in_slot   = SLOT_W'(slot);
        bus.in_header = HDR_W'({$urandom(), $urandom(),
                                $urandom(), $urandom()});
        last_acc = 1'b0;
        for (int n = 0; n < 20 && !last_acc; n++)
            tick();
        chk("accept", last_acc, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic set_plan(input int e, input int d, input bit r);
        plan_d[e] = d;
        plan_r[e] = r;
    endtask

    initial begin
        rnd               = 1'b0;
        reset             = 1'b1;
        slot_ctr          = 0;
        bus.in_valid      = 1'b0;
        bus.in_slot       = '0;
        bus.in_header     = '0;
        bus.eng_req_ready = '1;
        bus.eng_res_valid = '0;
        bus.eng_res       = '0;
        bus.out_ready     = 1'b1;
        for (int e = 0; e < NE; e++) begin
            fire_at[e] = -10;
            f_res[e]   = 1'b0;
            done_at[e] = 0;
            set_plan(e, 1, 1'b1);
        end
        m_reset();
        @(posedge clk);
        #1;
        cyc = 1;
        repeat (2) tick();
        reset = 1'b0;

        // single record answered pass
        set_plan(0, 2, 1'b1);
        send(5);
        repeat (8) tick();
        chk("t1_cnt_pass", bus.cnt_pass, 1);

        // reorder: second engine answers first, results stay in order
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        set_plan(0, 3, 1'b0);
        set_plan(1, 0, 1'b1);
        send(1);
        send(2);
        repeat (10) tick();
        chk("t2_cnt_pass", bus.cnt_pass, 1);
        chk("t2_cnt_drop", bus.cnt_drop, 1);

        // engine never answers in time
        set_plan(0, TMO + 2, 1'b1);
        set_plan(1, TMO + 2, 1'b1);
        send(3);
        repeat (10) tick();
        chk("t3_cnt_timeout", bus.cnt_timeout, 1);
        chk("t3_cnt_drop", bus.cnt_drop, 2);

        // both engines busy, output stalled, then one pop frees an engine
        set_plan(0, 0, 1'b1);
        set_plan(1, 0, 1'b0);
        bus.out_ready = 1'b0;
        send(10);
        send(11);
        bus.in_valid  = 1'b1;
        bus.in_slot   = SLOT_W'(12);
        repeat (10) tick();
        chk("t4_blocked", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        last_acc = 1'b0;
        for (int n = 0; n < 10 && !last_acc; n++)
            tick();
        chk("t4_accept", last_acc, 1'b1);
        bus.in_valid = 1'b0;
        repeat (10) tick();

        // reset while both engines wait; late responses must be ignored
        set_plan(0, 3, 1'b1);
        set_plan(1, 3, 1'b1);
        send(20);
        send(21);
        tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (8) tick();
        chk("t6_out_valid", bus.out_valid, 1'b0);
        chk("t6_cnt_pass", bus.cnt_pass, 0);
        chk("t6_cnt_drop", bus.cnt_drop, 0);

        // random traffic, random back-pressure, occasional reset
        rnd = 1'b1;
        repeat (3000) tick();
        rnd               = 1'b0;
        reset             = 1'b0;
        bus.in_valid      = 1'b0;
        bus.out_ready     = 1'b1;
        bus.eng_req_ready = '1;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule
